// File: rtl/tela_objetos_if.sv
// Pixel stream between the VGA timing generator, the renderer and the DAC pins:
// coordinate/sync coming in, colour and delayed sync going out.
interface tela_objetos_if;
    logic       pix_en;
    logic       ativo_in;
    logic       hs_in;
    logic       vs_in;
    logic [9:0] x_in;
    logic [9:0] y_in;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;

    modport master (
        output pix_en, ativo_in, hs_in, vs_in, x_in, y_in,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
    );

    modport slave (
        input  pix_en, ativo_in, hs_in, vs_in, x_in, y_in,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
    );
endinterface

// File: rtl/tela_objetos.sv
// Three-stage pixel renderer: NUM_OBJ coloured rectangles, bitmap game-over text
// from an external ROM and a blinking pause mode, with sync delayed to match.
module tela_objetos #(
    parameter int          NUM_OBJ   = 4,
    parameter int          ESCALA    = 10,
    parameter int          COLS      = 64,
    parameter int          BLINK_BIT = 4,
    parameter logic [23:0] COR_FUNDO = 24'h003232
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    tela_objetos_if.slave         vid,
    input  logic [NUM_OBJ*10-1:0] obj_x,
    input  logic [NUM_OBJ*10-1:0] obj_y,
    input  logic [NUM_OBJ*10-1:0] obj_w,
    input  logic [NUM_OBJ*10-1:0] obj_h,
    input  logic [NUM_OBJ*24-1:0] obj_cor,
    input  logic [NUM_OBJ-1:0]    obj_vis,
    input  logic [1:0]            modo,
    output logic [12:0]           texto_addr,
    input  logic                  texto_bit
);
    localparam logic [9:0]  ESC_MAX     = 10'(ESCALA - 1);
    localparam bit          COLS_POT2   = (COLS & (COLS - 1)) == 0;
    localparam int          COLS_SH     = $clog2(COLS);
    localparam logic [23:0] FUNDO_PAUSA = (COR_FUNDO >> 1) & 24'h7F7F7F;

    // stage 1
    logic [9:0]  sub_x_r, col_r, sub_y_r, row_r;
    logic [9:0]  sub_x_nx_s, col_nx_s, sub_y_nx_s, row_nx_s;
    logic [12:0] addr_nx_s, addr_r;
    logic [9:0]  x1_r, y1_r;
    logic [1:0]  modo1_r;
    logic        ativo1_r, hs1_r, vs1_r;
    // stage 2
    logic [NUM_OBJ-1:0] hit_s, hit2_r;
    logic        tbit2_r;
    logic [1:0]  modo2_r;
    logic        ativo2_r, hs2_r, vs2_r;
    // stage 3
    logic [23:0] obj_cor_s, rgb_nx_s, rgb_r;
    logic        hs3_r, vs3_r, blank3_r;
    // frame counter
    logic        vs_ant_r;
    logic [7:0]  frame_cnt_r;

    // Text cell counters: the updated value is the cell of the pixel being accepted
    always_comb begin
        sub_x_nx_s = sub_x_r;
        col_nx_s   = col_r;
        sub_y_nx_s = sub_y_r;
        row_nx_s   = row_r;
        if (vid.ativo_in) begin
            if (vid.x_in == 10'd0) begin
                sub_x_nx_s = 10'd0;
                col_nx_s   = 10'd0;
                if (vid.y_in == 10'd0) begin
                    sub_y_nx_s = 10'd0;
                    row_nx_s   = 10'd0;
                end else if (sub_y_r == ESC_MAX) begin
                    sub_y_nx_s = 10'd0;
                    row_nx_s   = row_r + 10'd1;
                end else begin
                    sub_y_nx_s = sub_y_r + 10'd1;
                end
            end else if (sub_x_r == ESC_MAX) begin
                sub_x_nx_s = 10'd0;
                col_nx_s   = col_r + 10'd1;
            end else begin
                sub_x_nx_s = sub_x_r + 10'd1;
            end
        end else begin
            sub_x_nx_s = sub_x_r;
            col_nx_s   = col_r;
        end
    end

    // ROM address row*COLS+col; a shift suffices for power-of-two strides
    always_comb begin
        if (COLS_POT2) begin
            addr_nx_s = (13'(row_nx_s) << COLS_SH) + 13'(col_nx_s);
        end else begin
            addr_nx_s = 13'(row_nx_s) * 13'(COLS) + 13'(col_nx_s);
        end
    end

    // Stage 1 registers: counters, ROM address, coordinate, mode and sync
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            sub_x_r  <= 10'd0;
            col_r    <= 10'd0;
            sub_y_r  <= 10'd0;
            row_r    <= 10'd0;
            addr_r   <= 13'd0;
            x1_r     <= 10'd0;
            y1_r     <= 10'd0;
            modo1_r  <= 2'd0;
            ativo1_r <= 1'b0;
            hs1_r    <= 1'b1;
            vs1_r    <= 1'b1;
        end else if (vid.pix_en) begin
            sub_x_r  <= sub_x_nx_s;
            col_r    <= col_nx_s;
            sub_y_r  <= sub_y_nx_s;
            row_r    <= row_nx_s;
            addr_r   <= addr_nx_s;
            x1_r     <= vid.x_in;
            y1_r     <= vid.y_in;
            modo1_r  <= modo;
            ativo1_r <= vid.ativo_in;
            hs1_r    <= vid.hs_in;
            vs1_r    <= vid.vs_in;
        end
    end

    // Half-open rectangle test; 11-bit sums so right/bottom edges never wrap
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            hit_s[i] = obj_vis[i]
                && ({1'b0, x1_r} >= {1'b0, obj_x[10*i +: 10]})
                && ({1'b0, x1_r} <  ({1'b0, obj_x[10*i +: 10]} + {1'b0, obj_w[10*i +: 10]}))
                && ({1'b0, y1_r} >= {1'b0, obj_y[10*i +: 10]})
                && ({1'b0, y1_r} <  ({1'b0, obj_y[10*i +: 10]} + {1'b0, obj_h[10*i +: 10]}));
        end
    end

    // Stage 2 registers: hit vector and the ROM bit for the stage-1 address
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            hit2_r   <= '0;
            tbit2_r  <= 1'b0;
            modo2_r  <= 2'd0;
            ativo2_r <= 1'b0;
            hs2_r    <= 1'b1;
            vs2_r    <= 1'b1;
        end else if (vid.pix_en) begin
            hit2_r   <= hit_s;
            tbit2_r  <= texto_bit;
            modo2_r  <= modo1_r;
            ativo2_r <= ativo1_r;
            hs2_r    <= hs1_r;
            vs2_r    <= vs1_r;
        end
    end

    // Lowest-index hit wins: scan downward so lower indices overwrite
    always_comb begin
        obj_cor_s = COR_FUNDO;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            obj_cor_s = hit2_r[i] ? obj_cor[24*i +: 24] : obj_cor_s;
        end
    end

    // Colour select by mode; mode 3 renders like play
    always_comb begin
        rgb_nx_s = 24'h000000;
        if (!ativo2_r) begin
            rgb_nx_s = 24'h000000;
        end else begin
            case (modo2_r)
                2'd1:    rgb_nx_s = tbit2_r ? 24'hFFFFFF : 24'hFF0000;
                2'd2:    rgb_nx_s = ((|hit2_r) && !frame_cnt_r[BLINK_BIT]) ? obj_cor_s : FUNDO_PAUSA;
                default: rgb_nx_s = obj_cor_s;
            endcase
        end
    end

    // Stage 3 registers drive the DAC pins
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            rgb_r    <= 24'h000000;
            hs3_r    <= 1'b1;
            vs3_r    <= 1'b1;
            blank3_r <= 1'b0;
        end else if (vid.pix_en) begin
            rgb_r    <= rgb_nx_s;
            hs3_r    <= hs2_r;
            vs3_r    <= vs2_r;
            blank3_r <= ativo2_r;
        end
    end

    // Frame counter advances on each falling edge of vs_in seen at pixel rate
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            vs_ant_r    <= 1'b1;
            frame_cnt_r <= 8'd0;
        end else if (vid.pix_en) begin
            vs_ant_r <= vid.vs_in;
            if (vs_ant_r && !vid.vs_in) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
        end
    end

    assign texto_addr      = addr_r;
    assign vid.VGA_R       = rgb_r[23:16];
    assign vid.VGA_G       = rgb_r[15:8];
    assign vid.VGA_B       = rgb_r[7:0];
    assign vid.VGA_HS      = hs3_r;
    assign vid.VGA_VS      = vs3_r;
    assign vid.VGA_BLANK_N = blank3_r;
endmodule

// File: doc/tela_objetos.md
Name: tela_objetos

Overview:
- Parametrised pixel renderer and successor of the single-bar/single-ball screen block.
- Sits between the VGA timing generator and the DAC pins. Takes the current pixel coordinate and sync from the timing generator, tests it against NUM_OBJ coloured rectangles, and adds game-over and pause modes.
- The game-over mode uses a bitmap text overlay read from an external ROM.
- The block is pipelined, and its sync outputs are delayed to stay aligned with the colour outputs.

Parameters:
NUM_OBJ, 4, number of rectangles rendered (1..8)
ESCALA, 10, text cell size in pixels (each side)
COLS, 64, text grid columns (ROM row stride)
BLINK_BIT, 4, frame-counter bit that gates object blinking in pause mode
COR_FUNDO, 24'h003232, background RGB in play mode

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-low reset
pix_en  in  1  pixel-rate enable (25 MHz tick); all pipeline stages advance only when high
ativo_in  in  1  active-video flag from timing generator
hs_in  in  1  horizontal sync from timing generator, active low
vs_in  in  1  vertical sync from timing generator, active low
x_in  in  10  active-area column, 0..639
y_in  in  10  active-area row, 0..479
obj_x  in  NUM_OBJ*10  rect left edges; object i occupies bits [10i+9:10i]
obj_y  in  NUM_OBJ*10  rect top edges
obj_w  in  NUM_OBJ*10  rect widths
obj_h  in  NUM_OBJ*10  rect heights
obj_cor  in  NUM_OBJ*24  rect RGB, {R,G,B}
obj_vis  in  NUM_OBJ  per-object enable
modo  in  2  0=play, 1=lost, 2=pause, 3=treated as play
texto_addr  out  13  ROM address (row*COLS+col)
texto_bit  in  1  ROM data, valid one pix_en tick after texto_addr
VGA_R  out  8  red
VGA_G  out  8  green
VGA_B  out  8  blue
VGA_HS  out  1  delayed hs_in
VGA_VS  out  1  delayed vs_in
VGA_BLANK_N  out  1  delayed ativo_in

Behaviour:
- Reset: reset is synchronous and active-low; all state updates only on a CLOCK_50 edge with reset low, regardless of pix_en.
  - Reset values: VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, texto_addr=0.
  - Pipeline valid/ativo bits, cell counters and the frame counter are all cleared.
- Update rule: when pix_en is low, every register holds its value.
- Latency: exactly 3 pix_en ticks from inputs to VGA_R/G/B and VGA_HS/VS/BLANK_N. Sync and ativo travel through a matching 3-stage shift.
- Stage 1 (text cell counters; no divider allowed):
  - On ativo_in with x_in==0: sub_x=0, col=0.
  - Otherwise on ativo_in: sub_x increments; when sub_x==ESCALA-1 it wraps to 0 and col increments.
  - On ativo_in with x_in==0 && y_in==0: sub_y=0, row=0.
  - On ativo_in with x_in==0 && y_in!=0: sub_y advances; when sub_y==ESCALA-1 it wraps and row increments.
  - texto_addr is registered as row*COLS+col using a shift when COLS is a power of 2. Coordinates and modo are registered.
- Stage 2 (hit test): for each object i, hit[i] = obj_vis[i] && x>=obj_x[i] && x<obj_x[i]+obj_w[i] && y>=obj_y[i] && y<obj_y[i]+obj_h[i].
  - Sums are 11 bits wide, so they do not wrap.
  - Edges are half-open: a width of 0 never hits.
  - The hit vector and texto_bit are registered.
- Stage 3 (colour select):
  - Not ativo: RGB=0.
  - modo 0/3: colour of the lowest-index hit object; COR_FUNDO if none.
  - modo 1: texto_bit ? FFFFFF : FF0000. Objects are ignored.
  - modo 2: background is COR_FUNDO with each channel >>1. Objects are drawn only when frame_cnt[BLINK_BIT]==0, otherwise they are hidden.
- frame_cnt (8 bits): increments once on each vs_in 1->0 transition, sampled on pix_en. It wraps from 255 to 0.
- A modo change mid-frame takes effect for pixels whose inputs enter stage 1 after the change. Pixels already in the pipeline are not affected.

Test Plan:
- Reset low for 2 cycles with pix_en=1 → RGB=0, HS=VS=1, BLANK_N=0. After release, the first valid colour appears on the 3rd pix_en tick.
- modo=0, obj0 at (100,50) w=20 h=10 cor=FFFFFF → pixel (119,50)=FFFFFF; pixel (120,50)=003232; pixel (100,60)=003232.
- Overlap test: obj0 red and obj1 green both cover (200,200) → output FF0000. Clear obj_vis[0] → output 00FF00. Set obj_w=0 → no hit.
- modo=1, ROM model returns a 1 at address 65 → pixels x 10..19, y 10..19 are FFFFFF and pixel (9,10) is FF0000. Addresses are checked against row*64+col at x=639, y=479 (address 3071).
- modo=2: drive 16 vs falling edges → objects are visible for frames 0..15 and hidden for frames 16..31. Background=001919.
- Assert reset mid-line with pix_en=0 → outputs take their reset values at the next CLOCK_50 edge; counters restart cleanly at the next x_in==0, y_in==0.
